multicycle_control32: RTL and testbench

- Multi-cycle control FSM for the 32-bit MIPS-subset core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the execute unit's ALUOp, ALUSrc, I_format, Sftmd and Jrn.
- Also drives PC update, the shared instruction/data memory handshake and register-file writeback.
- Sits between the instruction register and the existing decode, execute and memory units; replaces the single-cycle combinational controller.

---
 rtl/multicycle_control32_if.sv | 25 ++
 rtl/multicycle_control32.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_control32.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control32_if.sv
// Shared instruction/data memory handshake between the multi-cycle
// controller and the memory unit.
//
//   mem_req   : controller -> memory, request held until mem_ready
//   mem_we    : controller -> memory, write qualifier for mem_req
//   mem_ready : memory -> controller, completes the current request this cycle
//
// master: controller side.  slave: memory side.
interface multicycle_control32_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control32.sv
// Multi-cycle control FSM for the 32-bit MIPS-subset core.
//
// It steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the
// execute-unit controls, the PC update, the shared memory handshake and the
// register-file writeback. It also counts retired instructions.
//
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   Opcode              : instruction[31:26], stable after ir_load
//   Function_opcode     : instruction[5:0]
//   Zero                : ALU zero flag
//   mem                 : memory handshake (master side)
//   ir_load             : load instruction register from memory read data
//   pc_write, pc_src    : PC update strobe / source (00 +4, 01 branch, 10 jump, 11 rs)
//   ALUOp, ALUSrc, I_format, Sftmd, Jrn : static decode to the execute unit
//   reg_write, reg_dst, mem_to_reg      : register-file writeback controls
//   state               : current FSM state (debug)
//   illegal, bus_err    : one-cycle pulses on undecoded opcode / memory timeout
//   instret             : retired-instruction count (wraps)
module multicycle_control32 #(
  parameter int RA_REG   = 31,
  parameter int MAX_WAIT = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [5:0]             Opcode,
  input  logic [5:0]             Function_opcode,
  input  logic                   Zero,
  multicycle_control32_if.master mem,
  output logic                   ir_load,
  output logic                   pc_write,
  output logic [1:0]             pc_src,
  output logic [1:0]             ALUOp,
  output logic                   ALUSrc,
  output logic                   I_format,
  output logic                   Sftmd,
  output logic                   Jrn,
  output logic                   reg_write,
  output logic [1:0]             reg_dst,
  output logic                   mem_to_reg,
  output logic [2:0]             state,
  output logic                   illegal,
  output logic                   bus_err,
  output logic [31:0]            instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  // The wait counter only has to reach MAX_WAIT-1. The timeout fires on the
  // cycle that would make it MAX_WAIT.
  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  // The register-file mux applies RA_REG when reg_dst=10. The controller
  // carries the parameter only so that both sides share one parameter set.
  logic [4:0] unused_ra_idx;
  assign unused_ra_idx = 5'(RA_REG);

  logic [2:0]    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0]   instret_q, instret_d;

  // Instruction classes
  logic is_r, is_i, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr, is_legal;

  assign is_r     = (Opcode == 6'b000000);
  assign is_i     = (Opcode[5:3] == 3'b001);
  assign is_lw    = (Opcode == 6'b100011);
  assign is_sw    = (Opcode == 6'b101011);
  assign is_beq   = (Opcode == 6'b000100);
  assign is_bne   = (Opcode == 6'b000101);
  assign is_j     = (Opcode == 6'b000010);
  assign is_jal   = (Opcode == 6'b000011);
  assign is_jr    = is_r && (Function_opcode == 6'b001000);
  assign is_legal = is_r | is_i | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;

  assign ALUOp    = {is_r | is_i, is_beq | is_bne};
  assign ALUSrc   = is_i | is_lw | is_sw;
  assign I_format = is_i;
  assign Sftmd    = is_r && (Function_opcode[5:3] == 3'b000);
  assign Jrn      = is_jr;

  logic          wait_hit;
  logic [WW-1:0] wait_inc;

  assign wait_hit = (MAX_WAIT > 0) && (wait_q == WAIT_LAST);
  assign wait_inc = (MAX_WAIT > 0) ? wait_q + 1'b1 : '0;

  logic       mem_req_c, mem_we_c, ir_load_c, pc_write_c, reg_write_c;
  logic       mem_to_reg_c, illegal_c, bus_err_c, retire;
  logic [1:0] pc_src_c, reg_dst_c;

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    ir_load_c    = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 2'b00;
    reg_write_c  = 1'b0;
    reg_dst_c    = 2'b00;
    mem_to_reg_c = 1'b0;
    illegal_c    = 1'b0;
    bus_err_c    = 1'b0;
    retire       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_load_c  = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_hit) begin
          // Stay in FETCH with an unchanged PC, so the fetch is reissued.
          bus_err_c = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end

      S_DECODE: begin
        if (is_j) begin
          pc_write_c = 1'b1;
          pc_src_c   = 2'b10;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end else if (is_jal) begin
          state_d = S_WB;
        end else if (!is_legal) begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_beq || is_bne) begin
          // Branch is taken when Zero matches the sense of the opcode.
          pc_write_c = (Zero == is_beq);
          pc_src_c   = (Zero == is_beq) ? 2'b01 : 2'b00;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end else if (is_jr) begin
          pc_write_c = 1'b1;
          pc_src_c   = 2'b11;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_r || is_i) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = is_sw;
        if (mem.mem_ready) begin
          retire  = is_sw;
          state_d = is_sw ? S_FETCH : S_WB;
        end else if (wait_hit) begin
          bus_err_c = 1'b1;
          state_d   = S_FETCH;
        end else begin
          wait_d = wait_inc;
        end
      end

      S_WB: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
        if (is_r) begin
          reg_dst_c = 2'b01;
        end else if (is_lw) begin
          mem_to_reg_c = 1'b1;
        end else if (is_jal) begin
          // The PC already moved to PC+4 in FETCH. That value is the link
          // data, so the jump and the link write happen together here.
          reg_dst_c  = 2'b10;
          pc_write_c = 1'b1;
          pc_src_c   = 2'b10;
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign instret_d = instret_q + 32'(retire);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  // Strobes are gated by reset. An instruction that is abandoned by reset
  // then cannot touch memory, the PC or the register file while reset is held.
  assign mem.mem_req = mem_req_c & ~reset;
  assign mem.mem_we  = mem_we_c & ~reset;
  assign ir_load     = ir_load_c & ~reset;
  assign pc_write    = pc_write_c & ~reset;
  assign pc_src      = reset ? 2'b00 : pc_src_c;
  assign reg_write   = reg_write_c & ~reset;
  assign reg_dst     = reset ? 2'b00 : reg_dst_c;
  assign mem_to_reg  = mem_to_reg_c & ~reset;
  assign illegal     = illegal_c & ~reset;
  assign bus_err     = bus_err_c & ~reset;
  assign state       = state_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_control32.sv
module tb_multicycle_control32;
  localparam int MAX_WAIT = 15;

  localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_W = 3'd4;
  localparam int C_R = 0, C_JR = 1, C_I = 2, C_LW = 3, C_SW = 4, C_BEQ = 5,
                 C_BNE = 6, C_J = 7, C_JAL = 8, C_ILL = 9;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  Opcode = '0;
  logic [5:0]  Function_opcode = '0;
  logic        Zero = 1'b0;
  logic        ir_load, pc_write, ALUSrc, I_format, Sftmd, Jrn;
  logic        reg_write, mem_to_reg, illegal, bus_err;
  logic [1:0]  pc_src, ALUOp, reg_dst;
  logic [2:0]  state;
  logic [31:0] instret;

  multicycle_control32_if mem_if();

  multicycle_control32 #(.RA_REG(31), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .Function_opcode(Function_opcode),
    .Zero(Zero), .mem(mem_if), .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
    .ALUOp(ALUOp), .ALUSrc(ALUSrc), .I_format(I_format), .Sftmd(Sftmd), .Jrn(Jrn),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
    .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  always #5 clock = ~clock;

  // Per-cycle control word; pc_src is only meaningful with pc_write and the
  // writeback selects only with reg_write.
  logic [11:0] obs_ctl, raw_ctl;
  logic [5:0]  obs_dec;
  assign obs_ctl = {mem_if.mem_req, mem_if.mem_we, ir_load, pc_write,
                    pc_write ? pc_src : 2'b00, reg_write,
                    reg_write ? reg_dst : 2'b00, reg_write & mem_to_reg, illegal, bus_err};
  assign raw_ctl = {mem_if.mem_req, mem_if.mem_we, ir_load, pc_write, pc_src,
                    reg_write, reg_dst, mem_to_reg, illegal, bus_err};
  assign obs_dec = {ALUOp, ALUSrc, I_format, Sftmd, Jrn};

  typedef struct packed {
    logic [2:0]  st;
    logic [11:0] ctl;
    logic        rdy;
    logic        ret;
  } cyc_t;

  cyc_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_instret = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) return (fn == 6'b001000) ? C_JR : C_R;
    if (op[5:3] == 3'b001) return C_I;
    case (op)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000101: return C_BNE;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      default:   return C_ILL;
    endcase
  endfunction

  // {ALUOp, ALUSrc, I_format, Sftmd, Jrn}
  function automatic logic [5:0] dec_exp(input int cls, input logic [5:0] fn);
    logic rfmt;
    rfmt = (cls == C_R) || (cls == C_JR);
    return {rfmt || cls == C_I, cls == C_BEQ || cls == C_BNE,
            cls == C_I || cls == C_LW || cls == C_SW, cls == C_I,
            rfmt && fn[5:3] == 3'b000, cls == C_JR};
  endfunction

  function automatic logic [11:0] mkc(input logic req, input logic we, input logic irl,
                                      input logic pcw, input logic [1:0] pcs, input logic rw,
                                      input logic [1:0] rd, input logic m2r, input logic ill,
                                      input logic be);
    return {req, we, irl, pcw, pcs, rw, rd, m2r, ill, be};
  endfunction

  function automatic logic rnd();
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic add(input logic [2:0] st, input logic [11:0] ctl, input logic rdy, input logic ret);
    cyc_t c;
    c.st = st; c.ctl = ctl; c.rdy = rdy; c.ret = ret;
    q.push_back(c);
  endtask

  // Stall cycles of a memory phase; ok=0 when the timeout aborts it.
  task automatic mem_wait(input logic [2:0] st, input logic we, input int waits, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < waits; i++) begin
      if (MAX_WAIT > 0 && i == MAX_WAIT - 1) begin
        add(st, mkc(1, we, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1), 1'b0, 1'b0);
        ok = 1'b0;
        return;
      end
      add(st, mkc(1, we, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0), 1'b0, 1'b0);
    end
  endtask

  // Expected cycle-by-cycle trace of one instruction, from its class.
  task automatic build(input int cls, input logic zero, input int fw, input int mw);
    bit          ok;
    logic [11:0] idle;
    logic        tk;
    idle = mkc(0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
    mem_wait(ST_F, 1'b0, fw, ok);
    if (!ok) return;
    add(ST_F, mkc(1, 0, 1, 1, 2'b00, 0, 2'b00, 0, 0, 0), 1'b1, 1'b0);
    case (cls)
      C_J:   add(ST_D, mkc(0, 0, 0, 1, 2'b10, 0, 2'b00, 0, 0, 0), rnd(), 1'b1);
      C_ILL: add(ST_D, mkc(0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0), rnd(), 1'b0);
      C_JAL: begin
        add(ST_D, idle, rnd(), 1'b0);
        add(ST_W, mkc(0, 0, 0, 1, 2'b10, 1, 2'b10, 0, 0, 0), rnd(), 1'b1);
      end
      default: begin
        add(ST_D, idle, rnd(), 1'b0);
        case (cls)
          C_BEQ, C_BNE: begin
            tk = (cls == C_BEQ) ? zero : !zero;
            add(ST_E, mkc(0, 0, 0, tk, tk ? 2'b01 : 2'b00, 0, 2'b00, 0, 0, 0), rnd(), 1'b1);
          end
          C_JR: add(ST_E, mkc(0, 0, 0, 1, 2'b11, 0, 2'b00, 0, 0, 0), rnd(), 1'b1);
          C_LW, C_SW: begin
            add(ST_E, idle, rnd(), 1'b0);
            mem_wait(ST_M, cls == C_SW, mw, ok);
            if (!ok) return;
            add(ST_M, mkc(1, cls == C_SW, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0), 1'b1, cls == C_SW);
            if (cls == C_LW) add(ST_W, mkc(0, 0, 0, 0, 2'b00, 1, 2'b00, 1, 0, 0), rnd(), 1'b1);
          end
          C_R: begin
            add(ST_E, idle, rnd(), 1'b0);
            add(ST_W, mkc(0, 0, 0, 0, 2'b00, 1, 2'b01, 0, 0, 0), rnd(), 1'b1);
          end
          default: begin
            add(ST_E, idle, rnd(), 1'b0);
            add(ST_W, mkc(0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0, 0), rnd(), 1'b1);
          end
        endcase
      end
    endcase
  endtask

  // Entered shortly after a rising edge; leaves the same way. max_cyc<0 runs the whole trace.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                     input int fw, input int mw, input int max_cyc);
    int         n;
    int         cls;
    cyc_t       c;
    logic [5:0] de;
    n = 0;
    cls = classify(op, fn);
    de = dec_exp(cls, fn);
    q.delete();
    build(cls, zero, fw, mw);
    Opcode = op; Function_opcode = fn; Zero = zero;
    while (q.size() > 0 && (max_cyc < 0 || n < max_cyc)) begin
      c = q.pop_front();
      mem_if.mem_ready = c.rdy;
      @(negedge clock);
      chk($sformatf("state op=%b c%0d", op, n), 32'(state), 32'(c.st));
      chk($sformatf("ctl op=%b c%0d", op, n), 32'(obs_ctl), 32'(c.ctl));
      chk($sformatf("instret op=%b c%0d", op, n), instret, exp_instret);
      if (c.st != ST_F) chk($sformatf("decode op=%b fn=%b", op, fn), 32'(obs_dec), 32'(de));
      if (c.ret) exp_instret = exp_instret + 32'd1;
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  initial begin
    logic [5:0] op, fn;
    int         fw, mw;
    mem_if.mem_ready = 1'b0;

    @(negedge clock);
    chk("reset_state", 32'(state), 32'(ST_F));
    chk("reset_ctl", 32'(raw_ctl), 32'd0);
    chk("reset_instret", instret, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // R add with ready tied high, then lw/sw stalled 3 cycles per request
    run(6'b000000, 6'b100000, 1'b0, 0, 0, -1);
    run(6'b100011, 6'b000000, 1'b0, 3, 3, -1);
    run(6'b101011, 6'b000000, 1'b0, 3, 3, -1);
    // beq and bne both with Zero=1
    run(6'b000100, 6'b000000, 1'b1, 0, 0, -1);
    run(6'b000101, 6'b000000, 1'b1, 0, 0, -1);
    // illegal opcode followed by jal, then jr and a shift
    run(6'b111111, 6'b000000, 1'b0, 0, 0, -1);
    run(6'b000011, 6'b000000, 1'b0, 1, 0, -1);
    run(6'b000000, 6'b001000, 1'b0, 0, 0, -1);
    run(6'b000000, 6'b000010, 1'b0, 0, 0, -1);
    // fetch timeout, reissued fetch, and a load timeout in MEM
    run(6'b000010, 6'b000000, 1'b0, 20, 0, -1);
    run(6'b001101, 6'b000000, 1'b0, 0, 0, -1);
    run(6'b100011, 6'b000000, 1'b0, 0, 16, -1);

    // counter wrap on a retiring j
    force dut.instret_q = 32'hFFFF_FFFF;
    #2;
    release dut.instret_q;
    exp_instret = 32'hFFFF_FFFF;
    run(6'b000010, 6'b000000, 1'b0, 0, 0, -1);
    chk("instret_wrap", instret, exp_instret);

    // reset while sw waits in MEM
    run(6'b101011, 6'b000000, 1'b0, 0, 5, 4);
    mem_if.mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_state", 32'(state), 32'(ST_F));
    chk("midrst_ctl", 32'(raw_ctl), 32'd0);
    chk("midrst_instret", instret, 32'd0);
    @(negedge clock);
    chk("midrst_we", 32'(mem_if.mem_we), 32'd0);
    @(posedge clock);
    #1;
    chk("midrst_req", 32'(mem_if.mem_req), 32'd0);
    reset = 1'b0;
    exp_instret = '0;

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 10))
        0:       op = 6'b000000;
        1:       op = {3'b001, 3'($urandom)};
        2:       op = 6'b100011;
        3:       op = 6'b101011;
        4:       op = 6'b000100;
        5:       op = 6'b000101;
        6:       op = 6'b000010;
        7:       op = 6'b000011;
        8:       op = 6'b000000;
        default: op = 6'($urandom);
      endcase
      fn = 6'($urandom);
      if ($urandom_range(0, 3) == 0) fn = 6'b001000;
      fw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(15, 18)) : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(15, 18)) : int'($urandom_range(0, 3));
      run(op, fn, rnd(), fw, mw, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
